// File: rtl/result_packer_if.sv
// result_packer_if: result handshake and serialized 48-bit word stream of result_packer.
interface result_packer_if #(parameter int RES_W = 80);
  logic res_valid, res_ready, res_sel, dout_valid, dout_ready, busy, err_app;
  logic [2:0] res_app;
  logic [RES_W-1:0] res_data;
  logic [47:0] dataout;
  modport master (
    output res_valid, res_app, res_sel, res_data, dout_ready,
    input res_ready, dataout, dout_valid, busy, err_app
  );
  modport slave (
    input res_valid, res_app, res_sel, res_data, dout_ready,
    output res_ready, dataout, dout_valid, busy, err_app
  );
endinterface

// File: rtl/result_packer.sv
// result_packer: buffers wide results and serializes them into 48-bit host-link words.
// Define RESULT_PACKER_FIFO_EN to put a FIFO_DEPTH-entry result FIFO ahead of the serializer.
module result_packer #(
  parameter int RES_W = 80,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rstn,
  result_packer_if.slave bus
);
  localparam int NUM_PKT = RES_W / 40;
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_d;
  logic [RES_W-1:0] sh, ld_data;
  logic [2:0] app_q, ld_app, pkt;
  logic sel_q, ld_sel, load, rdy, err_q, hs, last, accept, app_ok;
  if (RES_W % 40 != 0 || RES_W < 40 || RES_W > 320 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("result_packer: unsupported RES_W or FIFO_DEPTH");
  end
  assign app_ok = !bus.res_app[2] && |bus.res_app[1:0];
  assign accept = bus.res_valid && bus.res_ready;
  assign bus.dout_valid = state == SEND;
  assign hs = bus.dout_valid && bus.dout_ready;
  assign last = bus.dout_valid && pkt == 3'(NUM_PKT - 1);
  assign bus.dataout = {app_q, last, sel_q, pkt, sh[RES_W-1 -: 40]};
  assign bus.err_app = err_q;
`ifdef RESULT_PACKER_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [RES_W+3:0] mem [FIFO_DEPTH];
  logic [AW:0] wp, rp;
  logic empty, full;
  assign empty = wp == rp;
  assign full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
  assign bus.res_ready = rdy && !full;
  assign bus.busy = bus.dout_valid || !empty;
  // pop on idle, or on the final handshake so results stream without a bubble
  assign load = !empty && (state == IDLE || (hs && last));
  assign {ld_app, ld_sel, ld_data} = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (accept && app_ok) wp <= wp + (AW+1)'(1);
      if (load) rp <= rp + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (accept && app_ok) mem[wp[AW-1:0]] <= {bus.res_app, bus.res_sel, bus.res_data};
`else
  assign bus.res_ready = rdy && !bus.dout_valid;
  assign bus.busy = bus.dout_valid;
  assign load = accept && app_ok;
  assign ld_app = bus.res_app;
  assign ld_sel = bus.res_sel;
  assign ld_data = bus.res_data;
`endif
  always_comb state_d = load ? SEND : (hs && last) ? IDLE : state;
  // rdy keeps res_ready low until the first clock after reset release
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      rdy <= 1'b0;
      err_q <= 1'b0;
      sh <= '0;
      app_q <= '0;
      sel_q <= 1'b0;
      pkt <= '0;
    end else begin
      state <= state_d;
      rdy <= 1'b1;
      err_q <= accept && !app_ok;
      if (load) begin
        sh <= ld_data;
        app_q <= ld_app;
        sel_q <= ld_sel;
        pkt <= '0;
      end else if (hs) begin
        sh <= sh << 40;
        pkt <= pkt + 3'd1;
      end
    end
endmodule

// File: tb/tb_result_packer.sv
// tb_result_packer: scoreboard bench for result_packer; expected words queued at accept, checked on output.
module tb_result_packer;
  localparam int RES_W = 80, FD = 4, NP = RES_W / 40;
`ifdef RESULT_PACKER_FIFO_EN
  localparam bit FIFO = 1'b1;
  localparam int CAP = FD + 1;
`else
  localparam bit FIFO = 1'b0;
  localparam int CAP = 1;
`endif
  logic clk = 1'b0, rstn = 1'b0;
  int tests = 0, fails = 0, cyc = 0;
  logic [47:0] q[$], seen_w[$];
  int seen_c[$];
  result_packer_if #(.RES_W(RES_W)) bus ();
  result_packer #(.RES_W(RES_W), .FIFO_DEPTH(FD)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push_res(input logic [2:0] app, input logic sel, input logic [RES_W-1:0] d);
    logic [RES_W-1:0] s;
    for (int i = 0; i < NP; i++) begin
      s = d >> (40 * (NP - 1 - i));
      q.push_back({app, i == NP - 1, sel, 3'(i), s[39:0]});
    end
  endtask
  task automatic send(input logic [2:0] app, input logic sel, input logic [RES_W-1:0] d,
                      input int wait_max, output bit acc);
    bus.res_valid = 1'b1;
    bus.res_app = app;
    bus.res_sel = sel;
    bus.res_data = d;
    acc = 1'b0;
    for (int i = 0; i < wait_max && !acc; i++) begin
      @(negedge clk);
      if (bus.res_ready) begin
        acc = 1'b1;
        if (!app[2] && app[1:0] != 2'b00) push_res(app, sel, d);
      end
      @(posedge clk);
      #1;
    end
    bus.res_valid = 1'b0;
  endtask
  task automatic wait_valid(input string tag, input int budget);
    for (int n = 0; n < budget && !bus.dout_valid; n++) begin
      @(posedge clk);
      #1;
    end
    chk(tag, 64'(bus.dout_valid), 64'd1);
  endtask
  task automatic drain(input string tag, input int budget);
    for (int n = 0; n < budget && (q.size() != 0 || bus.busy); n++) begin
      @(posedge clk);
      #1;
    end
    chk(tag, 64'(q.size()), 64'd0);
  endtask
  function automatic logic [RES_W-1:0] rnd();
    return {$urandom(), $urandom(), 16'($urandom())};
  endfunction
  always @(negedge clk)
    if (rstn && bus.dout_valid && bus.dout_ready) begin
      seen_w.push_back(bus.dataout);
      seen_c.push_back(cyc);
      chk("word_expected", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) chk("word", 64'(bus.dataout), 64'(q.pop_front()));
    end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bit acc;
    int b, na;
    logic [47:0] held;
    bus.res_valid = 1'b0;
    bus.res_app = '0;
    bus.res_sel = 1'b0;
    bus.res_data = '0;
    bus.dout_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", 64'({bus.dataout, bus.dout_valid, bus.res_ready, bus.busy, bus.err_app}), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("ready_pre", 64'(bus.res_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("ready_post", 64'(bus.res_ready), 64'd1);
    // single result
    bus.dout_ready = 1'b1;
    b = seen_w.size();
    send(3'b001, 1'b1, 80'h0123456789ABCDEF0123, 4, acc);
    chk("t1_acc", 64'(acc), 64'd1);
    chk("t1_lat", 64'(bus.dout_valid), 64'(!FIFO));
    chk("t1_err", 64'(bus.err_app), 64'd0);
    drain("t1_drain", 20);
    chk("t1_busy", 64'(bus.busy), 64'd0);
    chk("t1_n", 64'(seen_w.size() - b), 64'd2);
    if (seen_w.size() - b == 2) begin
      chk("t1_w0", 64'(seen_w[b]), 64'h280123456789);
      chk("t1_w1", 64'(seen_w[b+1]), 64'h39ABCDEF0123);
      chk("t1_gap", 64'(seen_c[b+1] - seen_c[b]), 64'd1);
    end
    // backpressure
    bus.dout_ready = 1'b0;
    b = seen_w.size();
    send(3'b011, 1'b0, 80'hFEDCBA9876543210AB5A, 4, acc);
    wait_valid("t2_valid", 4);
    held = bus.dataout;
    repeat (5) begin
      @(negedge clk);
      chk("t2_hold", 64'({bus.dout_valid, bus.dataout}), 64'({1'b1, held}));
    end
    @(posedge clk);
    #1;
    bus.dout_ready = 1'b1;
    drain("t2_drain", 20);
    chk("t2_n", 64'(seen_w.size() - b), 64'd2);
    if (seen_w.size() - b == 2) chk("t2_gap", 64'(seen_c[b+1] - seen_c[b]), 64'd1);
    // fill to capacity under backpressure
    bus.dout_ready = 1'b0;
    na = 0;
    b = seen_w.size();
    for (int i = 0; i < 6; i++) begin
      send(3'b010, i[0], rnd(), 3, acc);
      if (acc) na++;
    end
    chk("t3_acc", 64'(na), 64'(CAP));
    @(negedge clk);
    chk("t3_ready_lo", 64'(bus.res_ready), 64'd0);
    @(posedge clk);
    #1;
    bus.dout_ready = 1'b1;
    drain("t3_drain", 40);
    chk("t3_n", 64'(seen_w.size() - b), 64'(2 * CAP));
    for (int k = 0; k < seen_w.size() - b; k++) begin
      chk("t3_idx", 64'(seen_w[b+k][42:40]), 64'(k % 2));
      if (k > 0) chk("t3_gap", 64'(seen_c[b+k] - seen_c[b+k-1]), 64'd1);
    end
    @(negedge clk);
    chk("t3_ready_hi", 64'(bus.res_ready), 64'd1);
    @(posedge clk);
    #1;
    // back-to-back results
    b = seen_w.size();
    for (int i = 1; i <= 3; i++) send(3'(i), i[1], rnd(), 4, acc);
    drain("t4_drain", 30);
    chk("t4_n", 64'(seen_w.size() - b), 64'd6);
    for (int k = 0; k < seen_w.size() - b; k++) begin
      chk("t4_last", 64'(seen_w[b+k][44]), 64'(k % 2 == 1));
      if (k > 0)
        chk("t4_gap", 64'(seen_c[b+k] - seen_c[b+k-1]), 64'((k % 2 == 1 || FIFO) ? 1 : 2));
    end
    // unsupported app
    b = seen_w.size();
    send(3'b101, 1'b0, rnd(), 4, acc);
    chk("t5_acc", 64'(acc), 64'd1);
    chk("t5_err", 64'(bus.err_app), 64'd1);
    chk("t5_valid", 64'(bus.dout_valid), 64'd0);
    chk("t5_busy", 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1;
    chk("t5_err_clr", 64'(bus.err_app), 64'd0);
    chk("t5_none", 64'(seen_w.size() - b), 64'd0);
    // reset in the middle of a result
    bus.dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(3'b011, 1'b1, rnd(), 3, acc);
    wait_valid("t6_valid", 4);
    #2 rstn = 1'b0;
    #1;
    chk("t6_rst", 64'({bus.dataout, bus.dout_valid, bus.res_ready, bus.busy, bus.err_app}), 64'd0);
    q.delete();
    b = seen_w.size();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    bus.dout_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("t6_stale", 64'(seen_w.size() - b), 64'd0);
    chk("t6_busy", 64'(bus.busy), 64'd0);
    send(3'b010, 1'b0, rnd(), 4, acc);
    drain("t6_drain", 20);
    chk("t6_after_n", 64'(seen_w.size() - b), 64'd2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/result_packer.md
# result_packer

Transmit-side counterpart of the calc_ops operand collector. It accepts wide signed results from the arithmetic units over a valid/ready handshake and buffers them in a small FIFO. It serializes each result into 48-bit words that use the same field layout as the host→FPGA operand stream, and drives them back toward the host link.

## Interface
Parameters:
- RES_W, 80, result width; multiple of 40, range 40..320 (NUM_PKT = RES_W/40, at most 8)
- FIFO_DEPTH, 4, result FIFO entries; power of 2, at least 2 (used only with FIFO compiled in)

Ports:
- clk  in  1  single clock; all logic on posedge
- rstn  in  1  reset, asynchronous, active-low
- res_valid  in  1  result offered
- res_ready  out  1  result can be accepted
- res_app  in  3  application code of the result
- res_sel  in  1  select bit, echoed into header
- res_data  in  RES_W  result value (two's complement, passed through opaquely)
- dataout  out  48  serialized word
- dout_valid  out  1  dataout valid
- dout_ready  in  1  downstream accepts word
- busy  out  1  dout_valid OR FIFO non-empty
- err_app  out  1  one-cycle pulse: result with unsupported app discarded

## Operation
- Word format: [47:45]=app, [44]=last (1 on final packet of a result), [43]=sel, [42:40]=packet index, [39:0]=chunk.
- Packet i carries res_data[RES_W-1-40*i -: 40]. Packet 0 is the most-significant chunk; index counts 0..NUM_PKT-1.
- Accept occurs on a posedge with res_valid && res_ready.
- Supported apps are 001, 010 and 011; these are written to the FIFO as {app, sel, data}.
- Any other app is still accepted but not stored. err_app is high for exactly the cycle after the accept edge.
- Serializer states:
  - IDLE → SEND when the FIFO is non-empty: pop an entry and load the shift register plus the packet counter (0).
  - SEND: on dout_valid && dout_ready with packet < NUM_PKT-1, advance to the next packet.
  - SEND: on handshake of the last packet, if the FIFO is non-empty, pop and load the next result in the same edge (no bubble); otherwise go to IDLE.
- res_ready = !FIFO full, combinational; an accept and a pop may occur on the same edge.
- While dout_valid && !dout_ready, dataout is held stable. dout_valid never drops without a handshake, except on reset.

## Timing
- Reset (rstn low, asynchronous): dataout=0, dout_valid=0, res_ready=0, busy=0, err_app=0. FIFO pointers are cleared and the serializer goes to IDLE.
- Reset mid-result drops the partial result and all FIFO contents. No resumption.
- res_ready rises in the first cycle after rstn deasserts.
- Latency with idle serializer and empty FIFO: accept at edge k, then dout_valid=1 with packet 0 after edge k+1.
- Throughput: one word per cycle while dout_ready=1, including across result boundaries.
- Capacity: the serializer holds one result and the FIFO holds FIFO_DEPTH more. Full FIFO gives res_ready=0 until a pop.
- Simultaneous accept on full FIFO with a pop is not possible, because ready is already low.

## Configuration
- RESULT_PACKER_FIFO_EN defined: FIFO of FIFO_DEPTH entries as described above.
- Undefined:
  - No FIFO. The accept edge loads the serializer directly, so dout_valid=1 after edge k (latency 0 extra cycles).
  - res_ready = !busy (registered state), giving one idle cycle between consecutive results.
  - FIFO_DEPTH is ignored.
  - err_app behaviour is unchanged.

## Test plan
- Single result (FIFO on, RES_W=80): app=001, sel=1, data=0x0123456789_ABCDEF0123, dout_ready=1. Required output is 0x28_0123456789 then 0x39_ABCDEF0123 on consecutive cycles, after which busy=0.
- Backpressure: hold dout_ready=0 for 5 cycles while word 0 is valid. dataout and dout_valid must stay constant; word 1 follows one cycle after dout_ready rises.
- Fill: dout_ready=0, offer 6 results (app=010). Exactly 5 are accepted, then res_ready=0. Release dout_ready: 10 words with packet indices alternating 0/1 and no gaps, then res_ready=1.
- Back-to-back: 3 results with dout_ready=1. Required is 6 words on 6 consecutive cycles, with last=1 on words 2, 4 and 6.
- Bad app: app=101 is accepted. err_app=1 for one cycle, dout_valid stays 0 and FIFO occupancy is unchanged.
- Reset mid-result: assert rstn low while word 0 is valid with 2 results queued. All outputs go to 0 immediately; after release, no stale words are emitted.
